// File: rtl/block_hit_scanner_pkg.sv
// Shared types and constants for the block hit scanner: pixel layout, widths, scanner states.
`default_nettype none

package block_hit_scanner_pkg;

  localparam int PIXEL_W = 9;
  localparam int COORD_W = 8;
  localparam int SCORE_W = 9;
  localparam int NUM_PIX = 16;

  localparam int R_MSB = 8;
  localparam int G_MSB = 5;
  localparam int B_MSB = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    SCORE   = 3'd3,
    PUSH    = 3'd4,
    ADVANCE = 3'd5
  } scan_state_t;

  // R+G+B of one RGB333 pixel; 7+7+7 = 21 fits in 5 bits.
  function automatic logic [4:0] pixel_intensity(input logic [PIXEL_W-1:0] p);
    return {2'b00, p[R_MSB -: 3]} + {2'b00, p[G_MSB -: 3]} + {2'b00, p[B_MSB -: 3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/block_hit_scanner_hit_fifo.sv
// First-word fall-through FIFO holding hit coordinates; a push into a full FIFO succeeds only alongside a pop.
`default_nettype none

module hit_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              push_ok,
  output logic [DATA_W-1:0] head,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/block_hit_scanner.sv
// Walks the loader over every 4x4 block of the frame, scores each block and queues coordinates of blocks at or above threshold.
`default_nettype none

module block_hit_scanner #(
  parameter int BLOCKS_X   = 80,
  parameter int BLOCKS_Y   = 60,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [8:0] threshold,
  output logic       blk_start,
  output logic [7:0] blk_x,
  output logic [7:0] blk_y,
  input  logic       blk_done,
  input  logic [8:0] pixel_0,
  input  logic [8:0] pixel_1,
  input  logic [8:0] pixel_2,
  input  logic [8:0] pixel_3,
  input  logic [8:0] pixel_4,
  input  logic [8:0] pixel_5,
  input  logic [8:0] pixel_6,
  input  logic [8:0] pixel_7,
  input  logic [8:0] pixel_8,
  input  logic [8:0] pixel_9,
  input  logic [8:0] pixel_a,
  input  logic [8:0] pixel_b,
  input  logic [8:0] pixel_c,
  input  logic [8:0] pixel_d,
  input  logic [8:0] pixel_e,
  input  logic [8:0] pixel_f,
  output logic       hit_valid,
  output logic [7:0] hit_x,
  output logic [7:0] hit_y,
  input  logic       hit_ready,
  output logic       frame_done,
  output logic       overflow
);

  import block_hit_scanner_pkg::*;

  localparam logic [COORD_W-1:0] LAST_X = COORD_W'(BLOCKS_X - 1);
  localparam logic [COORD_W-1:0] LAST_Y = COORD_W'(BLOCKS_Y - 1);

  scan_state_t state;
  scan_state_t state_nxt;

  logic [PIXEL_W-1:0]   pix_in [NUM_PIX];
  logic [PIXEL_W-1:0]   pix_q  [NUM_PIX];
  logic [SCORE_W-1:0]   score;
  logic                 hit_q;
  logic                 last_x;
  logic                 last_blk;
  logic                 start_frame;
  logic                 push;
  logic                 push_ok;
  logic                 pop;
  logic                 fifo_empty;
  logic [2*COORD_W-1:0] fifo_head;

  always_comb begin
    pix_in[0]  = pixel_0;
    pix_in[1]  = pixel_1;
    pix_in[2]  = pixel_2;
    pix_in[3]  = pixel_3;
    pix_in[4]  = pixel_4;
    pix_in[5]  = pixel_5;
    pix_in[6]  = pixel_6;
    pix_in[7]  = pixel_7;
    pix_in[8]  = pixel_8;
    pix_in[9]  = pixel_9;
    pix_in[10] = pixel_a;
    pix_in[11] = pixel_b;
    pix_in[12] = pixel_c;
    pix_in[13] = pixel_d;
    pix_in[14] = pixel_e;
    pix_in[15] = pixel_f;
  end

  assign last_x      = (blk_x == LAST_X);
  assign last_blk    = last_x && (blk_y == LAST_Y);
  assign start_frame = enable && ((state == IDLE) || ((state == ADVANCE) && last_blk));
  assign push        = (state == PUSH) && hit_q;
  assign pop         = hit_valid && hit_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    blk_start = 1'b0;
    case (state)
      IDLE:    if (enable) state_nxt = ISSUE;
      ISSUE: begin
        blk_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:    if (blk_done) state_nxt = SCORE;
      SCORE:   state_nxt = PUSH;
      PUSH:    state_nxt = ADVANCE;
      ADVANCE: state_nxt = (last_blk && !enable) ? IDLE : ISSUE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pixels are only guaranteed on the done cycle, so they are captured here and scored next cycle.
  always_ff @(posedge clk) begin
    if (state == WAIT && blk_done) begin
      for (int i = 0; i < NUM_PIX; i++) begin
        pix_q[i] <= pix_in[i];
      end
    end
  end

  always_comb begin
    score = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      score = score + SCORE_W'(pixel_intensity(pix_q[i]));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blk_x      <= '0;
      blk_y      <= '0;
      hit_q      <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= (state == ADVANCE) && last_blk;
      if (start_frame) begin
        overflow <= 1'b0;
      end else if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (state == SCORE) begin
        hit_q <= (score >= threshold);
      end
      if (state == IDLE && enable) begin
        blk_x <= '0;
        blk_y <= '0;
      end else if (state == ADVANCE) begin
        if (last_x) begin
          blk_x <= '0;
          blk_y <= (blk_y == LAST_Y) ? '0 : blk_y + COORD_W'(1);
        end else begin
          blk_x <= blk_x + COORD_W'(1);
        end
      end
    end
  end

  hit_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (2*COORD_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({blk_x, blk_y}),
    .pop       (pop),
    .push_ok   (push_ok),
    .head      (fifo_head),
    .empty     (fifo_empty)
  );

  assign hit_valid = !fifo_empty;
  assign hit_x     = fifo_head[2*COORD_W-1:COORD_W];
  assign hit_y     = fifo_head[COORD_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_block_hit_scanner.sv
// Directed bench: two 2x2-frame scanners (FIFO depth 8 and 2) driven by a simple fixed-latency loader model.
`default_nettype none

module tb_block_hit_scanner;

  import block_hit_scanner_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [8:0] threshold;
  logic [8:0] pix;

  logic       en_a, hr_a, man_a, ld_a, auto_a;
  logic       bs_a, hv_a, fd_a, ov_a;
  logic [7:0] bx_a, by_a, hx_a, hy_a;
  logic       en_b, hr_b, ld_b, auto_b;
  logic       bs_b, hv_b, fd_b, ov_b;
  logic [7:0] bx_b, by_b, hx_b, hy_b;

  int checks = 0;
  int passed = 0;

  int ns_a = 0, ns_b = 0, fdc_a = 0, fdc_b = 0, pops_a = 0, pops_b = 0;
  int cnt_a = 0, cnt_b = 0;
  logic [15:0] sx_a [64];
  logic [15:0] exp4 [4];

  block_hit_scanner #(.BLOCKS_X(2), .BLOCKS_Y(2), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(en_a), .threshold(threshold),
    .blk_start(bs_a), .blk_x(bx_a), .blk_y(by_a), .blk_done(ld_a | man_a),
    .pixel_0(pix), .pixel_1(pix), .pixel_2(pix), .pixel_3(pix),
    .pixel_4(pix), .pixel_5(pix), .pixel_6(pix), .pixel_7(pix),
    .pixel_8(pix), .pixel_9(pix), .pixel_a(pix), .pixel_b(pix),
    .pixel_c(pix), .pixel_d(pix), .pixel_e(pix), .pixel_f(pix),
    .hit_valid(hv_a), .hit_x(hx_a), .hit_y(hy_a), .hit_ready(hr_a),
    .frame_done(fd_a), .overflow(ov_a)
  );

  block_hit_scanner #(.BLOCKS_X(2), .BLOCKS_Y(2), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(en_b), .threshold(threshold),
    .blk_start(bs_b), .blk_x(bx_b), .blk_y(by_b), .blk_done(ld_b),
    .pixel_0(pix), .pixel_1(pix), .pixel_2(pix), .pixel_3(pix),
    .pixel_4(pix), .pixel_5(pix), .pixel_6(pix), .pixel_7(pix),
    .pixel_8(pix), .pixel_9(pix), .pixel_a(pix), .pixel_b(pix),
    .pixel_c(pix), .pixel_d(pix), .pixel_e(pix), .pixel_f(pix),
    .hit_valid(hv_b), .hit_x(hx_b), .hit_y(hy_b), .hit_ready(hr_b),
    .frame_done(fd_b), .overflow(ov_b)
  );

  // Loader model: done pulse four cycles after each start.
  always @(posedge clk) begin
    ld_a <= 1'b0;
    if (!rst_n) cnt_a <= 0;
    else if (auto_a && bs_a) cnt_a <= 4;
    else if (cnt_a != 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) ld_a <= 1'b1;
    end
  end

  always @(posedge clk) begin
    ld_b <= 1'b0;
    if (!rst_n) cnt_b <= 0;
    else if (auto_b && bs_b) cnt_b <= 4;
    else if (cnt_b != 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) ld_b <= 1'b1;
    end
  end

  always @(posedge clk) begin
    if (bs_a) begin
      if (ns_a < 64) sx_a[ns_a] = {bx_a, by_a};
      ns_a++;
    end
    if (bs_b) ns_b++;
    if (fd_a) fdc_a++;
    if (fd_b) fdc_b++;
    if (hv_a && hr_a) pops_a++;
    if (hv_b && hr_b) pops_b++;
  end

  task automatic wait_fd(input bit sel, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((sel ? fdc_b : fdc_a) >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_starts(input bit sel, input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ((sel ? ns_b : ns_a) >= target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int base;
    rst_n = 1'b0; en_a = 0; en_b = 0; hr_a = 0; hr_b = 0; man_a = 0;
    auto_a = 0; auto_b = 0; threshold = 9'd0; pix = 9'h1FF;
    repeat (3) @(negedge clk);
    checks++;
    if ({bs_a, bx_a, by_a, hv_a, hx_a, hy_a, fd_a, ov_a} !== 36'd0)
      $display("FAIL reset_outputs: got %h expected 0", {bs_a, bx_a, by_a, hv_a, hx_a, hy_a, fd_a, ov_a});
    else passed++;
    checks++;
    if (u_a.state !== IDLE) $display("FAIL reset_state: got %0d expected %0d", u_a.state, IDLE);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    checks++;
    if (u_a.state !== WAIT) $display("FAIL pre_reset_wait: got %0d expected %0d", u_a.state, WAIT);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({u_a.state, bs_a, bx_a, by_a, hv_a, fd_a, ov_a} !== {IDLE, 20'd0})
      $display("FAIL midscan_reset: got %h expected %h", {u_a.state, bs_a, bx_a, by_a, hv_a, fd_a, ov_a}, {IDLE, 20'd0});
    else passed++;
    base = ns_a;
    repeat (4) @(negedge clk);
    man_a = 1'b1;
    @(negedge clk);
    man_a = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if ({hv_a, ns_a - base} !== {1'b0, 32'd0})
      $display("FAIL stale_done: got hit_valid=%b starts=%0d expected 0 0", hv_a, ns_a - base);
    else passed++;
    checks++;
    if (u_a.state !== IDLE) $display("FAIL stale_done_state: got %0d expected %0d", u_a.state, IDLE);
    else passed++;
  endtask

  task automatic test_full_frame;
    int bs, bf;
    bit ok;
    auto_a = 1'b1; threshold = 9'd300; pix = 9'h1FF; hr_a = 1'b0;
    bs = ns_a; bf = fdc_a;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    wait_fd(1'b0, bf + 1, ok);
    checks++;
    if (!ok) $display("FAIL frame_timeout: got no frame_done expected one");
    else passed++;
    repeat (10) @(negedge clk);
    checks++;
    if (fdc_a - bf !== 1) $display("FAIL frame_done_count: got %0d expected 1", fdc_a - bf);
    else passed++;
    checks++;
    if (ns_a - bs !== 4) $display("FAIL start_count: got %0d expected 4", ns_a - bs);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sx_a[bs + i] !== exp4[i]) $display("FAIL start_coord%0d: got %h expected %h", i, sx_a[bs + i], exp4[i]);
      else passed++;
    end
    hr_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({hv_a, hx_a, hy_a} !== {1'b1, exp4[i]})
        $display("FAIL fifo_entry%0d: got %h expected %h", i, {hv_a, hx_a, hy_a}, {1'b1, exp4[i]});
      else passed++;
      @(negedge clk);
    end
    hr_a = 1'b0;
    checks++;
    if ({hv_a, ov_a} !== 2'b00) $display("FAIL fifo_drained: got %b expected 00", {hv_a, ov_a});
    else passed++;
  endtask

  task automatic test_threshold;
    int bf, bp;
    bit ok;
    pix = 9'h049; threshold = 9'd48; hr_a = 1'b0;
    bf = fdc_a;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    wait_fd(1'b0, bf + 1, ok);
    bp = pops_a;
    hr_a = 1'b1;
    repeat (6) @(negedge clk);
    hr_a = 1'b0;
    checks++;
    if ({ok, 32'(pops_a - bp)} !== {1'b1, 32'd4})
      $display("FAIL thresh_equal_hit: got done=%b hits=%0d expected 1 4", ok, pops_a - bp);
    else passed++;
    threshold = 9'd49;
    bf = fdc_a;
    en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    wait_fd(1'b0, bf + 1, ok);
    repeat (2) @(negedge clk);
    checks++;
    if ({ok, hv_a} !== 2'b10) $display("FAIL thresh_above_miss: got done=%b hit_valid=%b expected 1 0", ok, hv_a);
    else passed++;
  endtask

  task automatic test_overflow;
    int bs, bf;
    bit ok;
    auto_b = 1'b1; threshold = 9'd0; pix = 9'h1FF; hr_b = 1'b0;
    bs = ns_b; bf = fdc_b;
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    wait_starts(1'b1, bs + 3, ok);
    checks++;
    if ({ok, hv_b, ov_b} !== 3'b110) $display("FAIL ovf_two_blocks: got %b expected 110", {ok, hv_b, ov_b});
    else passed++;
    wait_starts(1'b1, bs + 4, ok);
    checks++;
    if ({ok, ov_b} !== 2'b11) $display("FAIL ovf_third_block: got %b expected 11", {ok, ov_b});
    else passed++;
    wait_fd(1'b1, bf + 1, ok);
    checks++;
    if ({ok, ov_b, hv_b, hx_b, hy_b} !== {3'b111, 16'h0000})
      $display("FAIL ovf_head0: got %h expected %h", {ok, ov_b, hv_b, hx_b, hy_b}, {3'b111, 16'h0000});
    else passed++;
    hr_b = 1'b1;
    @(negedge clk);
    hr_b = 1'b0;
    checks++;
    if ({hv_b, hx_b, hy_b} !== {1'b1, 16'h0100})
      $display("FAIL ovf_head1: got %h expected %h", {hv_b, hx_b, hy_b}, {1'b1, 16'h0100});
    else passed++;
    bf = fdc_b;
    en_b = 1'b1;
    @(negedge clk);
    checks++;
    if (ov_b !== 1'b0) $display("FAIL ovf_cleared: got %b expected 0", ov_b);
    else passed++;
    en_b = 1'b0;
    wait_fd(1'b1, bf + 1, ok);
    hr_b = 1'b1;
    repeat (4) @(negedge clk);
    hr_b = 1'b0;
    checks++;
    if ({ok, hv_b} !== 2'b10) $display("FAIL ovf_drain: got %b expected 10", {ok, hv_b});
    else passed++;
  endtask

  task automatic test_push_pop_full;
    int bf;
    bit ok, found;
    threshold = 9'd0; hr_b = 1'b0;
    bf = fdc_b;
    en_b = 1'b1;
    @(negedge clk);
    en_b = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (u_b.state == PUSH && bx_b == 8'd0 && by_b == 8'd1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if ({found, u_b.u_fifo.count} !== {1'b1, 2'd2})
      $display("FAIL pp_full_before: got found=%b count=%0d expected 1 2", found, u_b.u_fifo.count);
    else passed++;
    hr_b = 1'b1;
    @(negedge clk);
    hr_b = 1'b0;
    checks++;
    if ({u_b.u_fifo.count, ov_b, hx_b, hy_b} !== {2'd2, 1'b0, 16'h0100})
      $display("FAIL pp_accept: got %h expected %h", {u_b.u_fifo.count, ov_b, hx_b, hy_b}, {2'd2, 1'b0, 16'h0100});
    else passed++;
    wait_fd(1'b1, bf + 1, ok);
    checks++;
    if ({ok, ov_b} !== 2'b11) $display("FAIL pp_last_dropped: got %b expected 11", {ok, ov_b});
    else passed++;
    hr_b = 1'b1;
    repeat (4) @(negedge clk);
    hr_b = 1'b0;
  endtask

  task automatic test_enable_drop;
    int bs, bf;
    bit ok;
    pix = 9'h1FF; threshold = 9'd300; hr_a = 1'b1;
    bs = ns_a; bf = fdc_a;
    en_a = 1'b1;
    wait_starts(1'b0, bs + 3, ok);
    en_a = 1'b0;
    wait_fd(1'b0, bf + 1, ok);
    repeat (20) @(negedge clk);
    hr_a = 1'b0;
    checks++;
    if ({ok, 32'(ns_a - bs), 32'(fdc_a - bf)} !== {1'b1, 32'd4, 32'd1})
      $display("FAIL drop_enable_counts: got done=%b starts=%0d frames=%0d expected 1 4 1", ok, ns_a - bs, fdc_a - bf);
    else passed++;
    checks++;
    if ({u_a.state, sx_a[bs + 3]} !== {IDLE, 16'h0101})
      $display("FAIL drop_enable_end: got %h expected %h", {u_a.state, sx_a[bs + 3]}, {IDLE, 16'h0101});
    else passed++;
  endtask

  initial begin
    exp4[0] = 16'h0000;
    exp4[1] = 16'h0100;
    exp4[2] = 16'h0001;
    exp4[3] = 16'h0101;
    test_reset();
    test_full_frame();
    test_threshold();
    test_overflow();
    test_push_pop_full();
    test_enable_drop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
